// File: rtl/faerie_cu_pkg.sv
// Faerie CU shared types: state encoding, opcode fields and decode helpers.
package faerie_cu_pkg;

   typedef enum logic [3:0] {
      IDLE, FETCH, ADDR, PTR, LOAD, ALU, STORE, BRANCH, HALT
   } state_t;

   localparam int MODE_HI = 3;
   localparam int MODE_LO = 2;
   localparam int CLS_HI  = 1;
   localparam int CLS_LO  = 0;
   localparam int CMP_BIT = 0;

   localparam logic [1:0] MODE_ZP  = 2'b00;
   localparam logic [1:0] MODE_PTR = 2'b01;
   localparam logic [1:0] MODE_ABS = 2'b10;
   localparam logic [1:0] MODE_IMM = 2'b11;

   localparam logic [1:0] CLS_ALU    = 2'b00;
   localparam logic [1:0] CLS_STORE  = 2'b10;
   localparam logic [1:0] CLS_BRANCH = 2'b11;

   function automatic logic [1:0] mode_of(input logic [3:0] op);
      return op[MODE_HI:MODE_LO];
   endfunction

   function automatic logic [1:0] cls_of(input logic [3:0] op);
      return op[CLS_HI:CLS_LO];
   endfunction

   // Stores and branches have no immediate form.
   function automatic logic is_illegal(input logic [3:0] op);
      return mode_of(op) == MODE_IMM &&
             (cls_of(op) == CLS_STORE || cls_of(op) == CLS_BRANCH);
   endfunction

   function automatic state_t exec_of(input logic [3:0] op);
      state_t s;
      if (op[CLS_HI] == CLS_ALU[CLS_HI]) s = LOAD;
      else if (cls_of(op) == CLS_STORE) s = STORE;
      else s = BRANCH;
      return s;
   endfunction

endpackage

// File: rtl/faerie_cu_wide_next.sv
// Faerie CU next-state logic: fetch, address, pointer and exec sequencing.
import faerie_cu_pkg::*;

module faerie_cu_wide_next #(
   parameter int ADDR_BYTES = 2,
   parameter int HALT_EN    = 1,
   localparam int IW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1
) (
   input  state_t          state,
   input  logic [IW-1:0]   idx,
   input  logic [3:0]      insn,
   input  logic [3:0]      rdata,
   input  logic            mem_ready,
   input  logic            halt,
   output state_t          state_nxt,
   output logic [IW-1:0]   idx_nxt
);

   localparam logic [IW-1:0] LAST = IW'(ADDR_BYTES - 1);

   state_t bnd;

   assign bnd = (HALT_EN != 0 && halt) ? HALT : FETCH;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      unique case (state)
         IDLE: state_nxt = FETCH;
         FETCH: if (mem_ready) begin
            idx_nxt = '0;
            if (is_illegal(rdata)) state_nxt = bnd;
            else if (mode_of(rdata) == MODE_IMM) state_nxt = exec_of(rdata);
            else state_nxt = ADDR;
         end
         ADDR: if (mem_ready) begin
            if (mode_of(insn) == MODE_ABS && idx != LAST) begin
               idx_nxt = idx + 1'b1;
            end else if (mode_of(insn) == MODE_PTR) begin
               state_nxt = PTR;
               idx_nxt   = LAST;
            end else begin
               state_nxt = exec_of(insn);
               idx_nxt   = '0;
            end
         end
         // Pointer bytes walk downward so AL is overwritten last.
         PTR: if (mem_ready) begin
            if (idx != '0) idx_nxt = idx - 1'b1;
            else state_nxt = exec_of(insn);
         end
         LOAD:   if (mem_ready) state_nxt = ALU;
         STORE:  if (mem_ready) state_nxt = bnd;
         ALU:    state_nxt = bnd;
         BRANCH: state_nxt = bnd;
         HALT:   if (!halt) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/faerie_cu_wide.sv
// Faerie second-generation control unit: ready-stalled memory sequencing,
// halt at instruction boundaries and illegal-encoding detection.
import faerie_cu_pkg::*;

module faerie_cu_wide #(
   parameter int ADDR_BYTES = 2,
   parameter int HALT_EN    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rdata,
   input  logic                  mem_ready,
   input  logic                  halt,
   output logic                  re,
   output logic                  we,
   output logic                  pc_addr,
   output logic                  zp_addr,
   output logic                  pc_inc,
   output logic [ADDR_BYTES-1:0] ar_we,
   output logic                  inc_al,
   output logic                  reset_b,
   output logic                  set_fr,
   output logic                  set_a,
   output logic                  branch,
   output logic                  illegal,
   output logic                  halted
);

   localparam int IW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
   localparam logic [ADDR_BYTES-1:0] ONE = ADDR_BYTES'(1);

   state_t          state, state_nxt;
   logic [IW-1:0]   idx, idx_nxt;
   logic [7:0]      insn;
   logic [1:0]      mode;
   logic            unused_hi;

   assign mode      = mode_of(insn[3:0]);
   assign unused_hi = ^insn[7:4];

   faerie_cu_wide_next #(
      .ADDR_BYTES (ADDR_BYTES),
      .HALT_EN    (HALT_EN)
   ) u_next (
      .state     (state),
      .idx       (idx),
      .insn      (insn[3:0]),
      .rdata     (rdata[3:0]),
      .mem_ready (mem_ready),
      .halt      (halt),
      .state_nxt (state_nxt),
      .idx_nxt   (idx_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         insn  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (state == FETCH && mem_ready) insn <= rdata;
      end
   end

   always_comb begin
      re      = 1'b0;
      we      = 1'b0;
      pc_addr = 1'b0;
      zp_addr = 1'b0;
      pc_inc  = 1'b0;
      ar_we   = '0;
      inc_al  = 1'b0;
      reset_b = 1'b0;
      set_fr  = 1'b0;
      set_a   = 1'b0;
      branch  = 1'b0;
      illegal = 1'b0;
      halted  = 1'b0;
      unique case (state)
         FETCH: begin
            re      = 1'b1;
            pc_addr = 1'b1;
            reset_b = 1'b1;
            pc_inc  = mem_ready;
            illegal = mem_ready && is_illegal(rdata[3:0]);
         end
         ADDR: begin
            re      = 1'b1;
            pc_addr = 1'b1;
            pc_inc  = mem_ready;
            if (mem_ready) ar_we = ONE << idx;
         end
         PTR: begin
            re      = 1'b1;
            zp_addr = 1'b1;
            if (mem_ready) begin
               ar_we  = ONE << idx;
               inc_al = idx != '0;
            end
         end
         LOAD, STORE: begin
            re      = state == LOAD;
            we      = state == STORE;
            pc_addr = mode == MODE_IMM;
            pc_inc  = mode == MODE_IMM && mem_ready;
            zp_addr = mode == MODE_ZP;
         end
         ALU: begin
            set_fr = 1'b1;
            set_a  = !insn[CMP_BIT];
         end
         BRANCH:  branch = 1'b1;
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/faerie_cu_wide.md
Name: faerie_cu_wide

Overview:
Parametrised second-generation Faerie control unit. It sequences instruction fetch, operand/address fetch, pointer indirection, load/ALU, store and branch over an address register of ADDR_BYTES bytes. Unlike the first-generation CU, it stalls every memory access on a ready handshake, supports a halt request at instruction boundaries, and flags illegal encodings. It sits between the memory bus interface and the datapath (PC, AR, A, B, flags).

Parameters:
ADDR_BYTES, 2, address register width in bytes; legal range 1..4.
HALT_EN, 1, 1 = honour halt input; 0 = halt ignored and the HALT state is unreachable.

Ports:
clk  in  1  CPU clock.
rst  in  1  Reset; asynchronous, active-high.
rdata  in  8  Memory read data; valid in the cycle mem_ready=1.
mem_ready  in  1  Current read or write completes this cycle.
halt  in  1  Halt request; sampled at instruction boundary.
re  out  1  Memory read request.
we  out  1  Memory write request.
pc_addr  out  1  Bus address = PC, else AR.
zp_addr  out  1  Bus address = zero-page form of AR.
pc_inc  out  1  Increment PC (pulse).
ar_we  out  ADDR_BYTES  One-hot write strobe for AR byte k (pulse).
inc_al  out  1  Increment AR byte 0 (pulse).
reset_b  out  1  Clear B register.
set_fr  out  1  Write flags.
set_a  out  1  Write ALU result to A.
branch  out  1  Load PC from AR if condition holds.
illegal  out  1  Illegal encoding (one-cycle pulse).
halted  out  1  CU is in HALT.

Behaviour:
- State register uses states IDLE, FETCH, ADDR, PTR, LOAD, ALU, STORE, BRANCH, HALT, plus a byte counter idx (0..ADDR_BYTES-1) and an 8-bit insn register.
- Reset forces state=IDLE, idx=0, insn=0. All outputs are 0 while rst is high and in IDLE. IDLE always goes to FETCH on the next cycle.
- Memory states are FETCH, ADDR, PTR, LOAD and STORE. Each holds its state and outputs until mem_ready=1, then advances. ALU and BRANCH last exactly 1 cycle.
- Strobes pc_inc, ar_we, inc_al and illegal are asserted only in the mem_ready cycle (or in the single cycle of a non-memory event).
- FETCH:
  - Outputs: re=1, pc_addr=1, reset_b=1.
  - On ready: insn<=rdata, pc_inc=1. The next state is decoded from rdata directly.
- Mode insn[3:2]:
  - 00 zero-page: ADDR with 1 byte, then exec; the operand access uses zp_addr=1.
  - 01 pointer: ADDR with 1 byte, then PTR, then exec.
  - 10 absolute: ADDR with ADDR_BYTES bytes, then exec.
  - 11 immediate: go straight to exec; the operand is at PC.
- ADDR:
  - Outputs: re=1, pc_addr=1.
  - Bytes are fetched low first, idx counting up from 0.
  - Each ready pulses ar_we[idx] and pc_inc.
  - After the last byte, idx<=0.
- PTR:
  - Outputs: re=1, zp_addr=1.
  - Bytes are fetched from idx=ADDR_BYTES-1 down to 0.
  - Each ready pulses ar_we[idx]; it also pulses inc_al, except on byte 0.
  - Byte 0 overwrites AL last.
  - Wrap of AL past 0xFF is a datapath concern; the CU does not check it.
- Exec class insn[1:0]:
  - 0x: LOAD, then ALU. LOAD: re=1; pc_addr=1 and pc_inc on ready when mode=11; zp_addr=1 when mode=00.
  - 10: STORE with we=1, addressing as for LOAD.
  - 11: BRANCH with branch=1.
- ALU: set_fr=1; set_a=!insn[0] (insn[0]=1 is compare-only).
- Illegal encodings are STORE with mode 11 and BRANCH with mode 11. They are detected at decode: illegal=1 for the cycle entering the next FETCH, no memory access occurs, and the PC has advanced only past the opcode.
- Instruction boundary is the cycle after ALU, STORE-ready, BRANCH, or an illegal pulse.
  - If HALT_EN and halt=1 at the boundary: go to HALT, with halted=1 and all other outputs 0.
  - From HALT: go to FETCH the first cycle halt=0.
  - Otherwise the boundary goes to FETCH.
- ADDR_BYTES=1: absolute mode behaves as zero-page but without zp_addr; PTR fetches 1 byte and never pulses inc_al.
- mem_ready while re=we=0 is ignored.
- Asynchronous rst mid-access drops re/we immediately; no partial strobes.

Decomposition:
- Package faerie_cu_pkg holds:
  - the state enum;
  - mode constants MODE_ZP/PTR/ABS/IMM;
  - class constants CLS_ALU/STORE/BRANCH;
  - the insn field slices, as localparam bit positions.
- One sub-module, faerie_cu_wide_next, computes next state and next idx combinationally from state, idx, insn/rdata, mem_ready and halt.
- The top level holds the registers and output decode.

Test Plan:
- Reset, then FETCH of rdata=0x08 (abs, ALU, A-write), ADDR_BYTES=2, mem_ready always 1 -> re for 4 cycles; ar_we=01 then 10; ALU cycle with set_a=1, set_fr=1; then FETCH.
- Pointer insn 0x04, ADDR_BYTES=3, mem_ready=1 every 2nd cycle -> ADDR idx0; PTR ar_we 100, 010, 001; inc_al pulses exactly 2; each strobe coincides with ready.
- Immediate 0x0D (compare) -> LOAD with pc_addr=1 and pc_inc pulse; ALU with set_a=0, set_fr=1.
- Store-immediate 0x0E -> illegal pulses once, no we, next state FETCH with the PC advanced by 1.
- halt=1 during a BRANCH insn 0x0B (abs) -> branch=1 for one cycle, then halted=1; hold for 5 cycles, release -> FETCH next cycle; with HALT_EN=0, halted never rises.
- rst asserted mid-PTR with mem_ready=0 -> all outputs 0 in the same cycle; after release, IDLE for 1 cycle, then FETCH.
